// File: rtl/q5_17_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : q5_17_serial_tx
// Description : Parallel-to-serial word transmitter. Accepts a WIDTH-bit word
//               on a valid/ready handshake and shifts it out LSB first, one
//               bit per clock, with frame/sof/eof strobes that let the
//               downstream serial complementer restart on every word.
// Revision    : 1.0 - initial release
// ============================================================================
module q5_17_serial_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             stream,
  output logic             frame,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [1:0]      S_IDLE   = 2'd0;
  localparam logic [1:0]      S_SHIFT  = 2'd1;
  localparam logic [1:0]      S_GAP    = 2'd2;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  // Gap counter counts down to zero, so it is preloaded one short.
  localparam logic [3:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic            NO_GAP   = (GAP_CYCLES == 0);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;

  logic w_take;
  logic w_last;

  assign w_take = din_valid & din_ready;
  assign w_last = (bitcnt_q == LAST_BIT);

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  // Next-state and datapath update: load on transfer, shift per bit, count gap.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_take) begin
          state_d  = S_SHIFT;
          shreg_d  = din;
          bitcnt_d = '0;
        end
      end
      S_SHIFT: begin
        shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
        bitcnt_d = bitcnt_q + CW'(1);
        if (w_last) begin
          bitcnt_d = '0;
          if (!NO_GAP) begin
            state_d  = S_GAP;
            gapcnt_d = GAP_LOAD;
          end else if (w_take) begin
            // Back-to-back: next word starts on the very next cycle.
            shreg_d = din;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gapcnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only; din_ready has no din path.
  always_comb begin
    frame     = (state_q == S_SHIFT);
    stream    = frame & shreg_q[0];
    sof       = frame & (bitcnt_q == '0);
    eof       = frame & w_last;
    busy      = (state_q != S_IDLE);
    din_ready = (state_q == S_IDLE) | (frame & w_last & NO_GAP);
  end

endmodule
`default_nettype wire

// File: doc/q5_17_serial_tx.md
# q5_17_serial_tx

Parallel-to-serial word transmitter that feeds the serial two's complementer. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock, on `stream`. It also emits framing strobes (`frame`, `sof`, `eof`) so the downstream complementer can be restarted on every word boundary. It sits directly upstream of the complementer and shares its clock.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..32.
- `GAP_CYCLES`, default 1: idle cycles inserted after each word; legal range 0..15. A value of 0 permits back-to-back words.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `din`, input, WIDTH: word to transmit; sampled on an accepted transfer.
- `din_valid`, input, 1: `din` is valid.
- `din_ready`, output, 1: block can accept a word this cycle.
- `stream`, output, 1: serial data, LSB first; 0 whenever `frame` is 0.
- `frame`, output, 1: high during every bit cycle of a word.
- `sof`, output, 1: high during bit 0 only.
- `eof`, output, 1: high during bit WIDTH-1 only.
- `busy`, output, 1: high in every state other than IDLE.

## Operation
- FSM states:
  - IDLE: the state on reset.
  - SHIFT: bits are being sent.
  - GAP: enforced idle time after a word.
- Transfer rule: a transfer occurs on a rising edge where `din_valid` and `din_ready` are both 1. No transfer occurs while `rst` is high.
- `din_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT during bit WIDTH-1 when `GAP_CYCLES`=0.
  - 0 otherwise.
- IDLE -> SHIFT on a transfer. On that edge `din` is loaded into the shift register and the bit counter is cleared to 0.
- SHIFT:
  - `stream` = shift_reg[0] and `frame`=1.
  - The register shifts right and the counter increments on each edge.
  - At counter = WIDTH-1:
    - If `GAP_CYCLES`>0: next state is GAP with the gap counter loaded to `GAP_CYCLES`-1.
    - Else, on a transfer: stay in SHIFT, reload the shift register, clear the counter.
    - Else: go to IDLE.
- GAP: `frame`=0, `stream`=0. Decrement the gap counter; go to IDLE when it reaches 0.
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is 4 bits.
- `din` changes while not accepted have no effect. The loaded word is immune to later `din` changes.
- `sof`/`eof` with WIDTH=2: bit 0 gives `sof`=1, `eof`=0; bit 1 gives `sof`=0, `eof`=1. The two are never high together.

## Timing
- Reset values while `rst` is high: state IDLE; `stream`=0, `frame`=0, `sof`=0, `eof`=0, `busy`=0, `din_ready`=1 (ignored); shift register and counters 0.
- Latency: if the transfer happens at edge N, bit k appears on `stream` in the cycle after edge N+k, for k = 0..WIDTH-1.
- `frame`, `stream`, `sof`, `eof` and `busy` are registered or decoded from registered state only. They have no combinational path from `din`/`din_valid`.
- Word throughput: one word per WIDTH+`GAP_CYCLES`+1 cycles when `GAP_CYCLES`>0 (the +1 is the IDLE cycle). One word per WIDTH cycles when `GAP_CYCLES`=0 and `din_valid` is held high.
- Reset asserted mid-word: all outputs return to their reset values immediately (asynchronous). The partial word is discarded and is not resumed after release.
- First transfer after reset release: possible on the first rising edge with `rst` low.

## Test plan
- Reset values: WIDTH=8, hold `rst`=1 for 3 cycles, then release -> all outputs at reset values; IDLE; first `din_valid` is accepted on the next edge.
- Single word, standalone: `din`=8'h0B, valid for one cycle -> `stream` = 1,1,0,1,0,0,0,0 over 8 cycles; `sof` only on the first bit, `eof` only on the last; `frame` high 8 cycles; 1 GAP cycle; `din_ready` low from the accept to the IDLE return.
- Single word, through the complementer: same 8'h0B -> serial output collected = 8'hF5. Repeat with 8'h80 -> 8'h80, and 8'h00 -> 8'h00.
- Back-to-back: `GAP_CYCLES`=0, `din_valid` held high, words 8'hA5 then 8'h3C -> 16 contiguous `frame` cycles; `sof` at cycles 0 and 8; second word accepted during the first word's bit 7.
- Stalls: during SHIFT, drive `din_valid`=1 with `din`=8'hFF -> not accepted; transmitted bits unchanged; 8'hFF is accepted only after the IDLE return.
- Reset mid-word: assert `rst` during bit 3 of 8'hFF -> `stream`/`frame` drop to 0 in the same cycle; after release `busy`=0 and the next word is sent from bit 0.
